// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, multiplier FSM states, Booth codes, adder modes.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Booth select codes {Q[0], q_m1}
   localparam logic [1:0] BOOTH_NOP0 = 2'b00;
   localparam logic [1:0] BOOTH_ADD  = 2'b01;
   localparam logic [1:0] BOOTH_SUB  = 2'b10;
   localparam logic [1:0] BOOTH_NOP1 = 2'b11;

   // Adder M pin values
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // True sign of the (WIDTH+1)-bit result of a +/- b, recovered from the WIDTH-bit sum
   function automatic logic true_sign(input logic a_msb, input logic b_msb,
                                      input logic sum_msb, input logic sub);
      logic ovf;
      if (sub) ovf = (a_msb != b_msb) & (sum_msb != a_msb);
      else     ovf = (a_msb == b_msb) & (sum_msb != a_msb);
      return sum_msb ^ ovf;
   endfunction

endpackage : alu_pkg

// File: rtl/Adder_subtractor.sv
// 32-bit ripple-style adder/subtractor: sum = a + b (M=0) or a - b (M=1).
module Adder_subtractor
   import alu_pkg::*;
(
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   input  logic                 M,
   output logic [ALU_WIDTH-1:0] sum,
   output logic                 c_out
);

   logic [ALU_WIDTH-1:0] b_eff;

   // Subtract as a + ~b + 1
   always_comb begin
      b_eff        = b ^ {ALU_WIDTH{M}};
      {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + (ALU_WIDTH+1)'(M);
   end

endmodule : Adder_subtractor

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth signed multiplier, one Booth step per cycle through the shared adder.
module booth_multiplier_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   state_e               state_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     q_q;
   logic [WIDTH-1:0]     m_q;
   logic                 q_m1_q;
   logic [CNT_W-1:0]     count_q;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   product_q;

   logic [1:0]           booth_sel_c;
   logic                 adder_mode_c;
   logic                 use_sum_c;
   logic [WIDTH-1:0]     sum_c;
   logic                 c_out_c;
   logic [WIDTH-1:0]     res_c;
   logic                 sign_c;
   logic [WIDTH-1:0]     a_d;
   logic [WIDTH-1:0]     q_d;
   logic                 last_step_c;

   // The adder's carry out has no role in Booth recoding
   logic                 c_out_unused;
   assign c_out_unused = c_out_c;

   Adder_subtractor u_addsub (
      .a     (a_q),
      .b     (m_q),
      .M     (adder_mode_c),
      .sum   (sum_c),
      .c_out (c_out_c)
   );

   // Booth decode, overflow-corrected sign and arithmetic right shift of {A,Q}
   always_comb begin
      booth_sel_c  = {q_q[0], q_m1_q};
      adder_mode_c = MODE_ADD;
      use_sum_c    = 1'b0;
      unique case (booth_sel_c)
         BOOTH_ADD: use_sum_c = 1'b1;
         BOOTH_SUB: begin
            adder_mode_c = MODE_SUB;
            use_sum_c    = 1'b1;
         end
         BOOTH_NOP0, BOOTH_NOP1: use_sum_c = 1'b0;
         default:                use_sum_c = 1'b0;
      endcase
      res_c = use_sum_c ? sum_c : a_q;
      if (use_sum_c) sign_c = true_sign(a_q[WIDTH-1], m_q[WIDTH-1], sum_c[WIDTH-1], adder_mode_c);
      else           sign_c = a_q[WIDTH-1];
      a_d         = {sign_c, res_c[WIDTH-1:1]};
      q_d         = {res_c[0], q_q[WIDTH-1:1]};
      last_step_c = (count_q == CNT_W'(WIDTH - 1));
   end

   // Control FSM together with the iteration datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         q_m1_q    <= 1'b0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= multiplicand;
                  q_q     <= multiplier;
                  a_q     <= '0;
                  q_m1_q  <= 1'b0;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               a_q     <= a_d;
               q_q     <= q_d;
               q_m1_q  <= q_q[0];
               count_q <= count_q + CNT_W'(1);
               if (last_step_c) begin
                  product_q <= {a_d, q_d};
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule : booth_multiplier_seq

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: directed and random products against a plain arithmetic model.
module tb_booth_multiplier_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int n_checks;
   int n_errors;

   booth_multiplier_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   // Reference: exact signed product by sign-extending both operands to 64 bits
   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xe;
      logic [63:0] ye;
      xe = {{32{x[31]}}, x};
      ye = {{32{y[31]}}, y};
      return xe * ye;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full multiply from IDLE; checks busy window, done timing/width and result
   task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input string tag);
      int          busy_cnt;
      int          done_at;
      int          done_cnt;
      int          overlap;
      logic [63:0] got;
      start        = 1'b1;
      multiplicand = x;
      multiplier   = y;
      step();
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      busy_cnt = busy ? 1 : 0;
      done_at  = -1;
      done_cnt = 0;
      overlap  = (busy && done) ? 1 : 0;
      got      = '0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (busy) busy_cnt++;
         if (busy && done) overlap++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = i;
               got     = product;
            end
         end
      end
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, " done_edge"},   64'(done_at),  64'd32);
      check({tag, " done_width"},  64'(done_cnt), 64'd1);
      check({tag, " busy_done"},   64'(overlap),  64'd0);
      check({tag, " product"},     got,           ref_mul(x, y));
      check({tag, " held"},        product,       ref_mul(x, y));
   endtask

   initial begin
      int          busy_cnt;
      int          done_at;
      int          first_low;
      int          dcount;
      int          stable_err;
      int          done_t[2];
      logic [63:0] prod_s[2];
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] edge_vals[4];

      n_checks     = 0;
      n_errors     = 0;
      clk          = 1'b0;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      edge_vals[0] = 32'h8000_0000;
      edge_vals[1] = 32'hFFFF_FFFF;
      edge_vals[2] = 32'h7FFF_FFFF;
      edge_vals[3] = 32'h0000_0000;

      // Reset state
      repeat (3) step();
      check("reset busy",    64'(busy), 64'd0);
      check("reset done",    64'(done), 64'd0);
      check("reset product", product,   64'd0);
      rst_n = 1'b1;
      step();

      // Directed products
      run_mul(32'd3,          32'd4,          "3x4");
      run_mul(32'hFFFF_FFF9,  32'd6,          "m7x6");
      run_mul(32'hFFFF_FFFF,  32'hFFFF_FFFF,  "m1xm1");
      run_mul(32'h8000_0000,  32'h8000_0000,  "minxmin");
      run_mul(32'h8000_0000,  32'd1,          "minx1");
      run_mul(32'h7FFF_FFFF,  32'h8000_0000,  "maxxmin");

      // Random products, with extreme operands mixed in
      for (int n = 0; n < 20; n++) begin
         x = $urandom;
         y = $urandom;
         if ($urandom_range(0, 3) == 0) x = edge_vals[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) y = edge_vals[$urandom_range(0, 3)];
         run_mul(x, y, $sformatf("rand%0d", n));
      end

      // Start during RUN must be ignored
      start        = 1'b1;
      multiplicand = 32'd5;
      multiplier   = 32'd6;
      step();
      busy_cnt  = busy ? 1 : 0;
      done_at   = -1;
      first_low = -1;
      prod_s[0] = '0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 10) begin
            start        = 1'b1;
            multiplicand = 32'd100;
            multiplier   = 32'd100;
         end else begin
            start = 1'b0;
         end
         step();
         if (busy) busy_cnt++;
         if (!busy && first_low < 0) first_low = i;
         if (done && done_at < 0) begin
            done_at   = i;
            prod_s[0] = product;
         end
      end
      check("ignore busy_cycles", 64'(busy_cnt),  64'd32);
      check("ignore busy_low",    64'(first_low), 64'd32);
      check("ignore done_edge",   64'(done_at),   64'd32);
      check("ignore product",     prod_s[0],      ref_mul(32'd5, 32'd6));

      // Asynchronous reset mid-run discards the operation
      start        = 1'b1;
      multiplicand = 32'd5;
      multiplier   = 32'd6;
      step();
      start = 1'b0;
      repeat (14) step();
      rst_n = 1'b0;
      #1;
      check("midrst busy",    64'(busy), 64'd0);
      check("midrst done",    64'(done), 64'd0);
      check("midrst product", product,   64'd0);
      step();
      rst_n = 1'b1;
      dcount   = 0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done) dcount++;
         if (busy) busy_cnt++;
      end
      check("midrst no_done", 64'(dcount),   64'd0);
      check("midrst no_busy", 64'(busy_cnt), 64'd0);
      run_mul(32'd2, 32'd9, "after_rst");

      // Back-to-back: start held high, operands changed after first accept
      start        = 1'b1;
      multiplicand = 32'd7;
      multiplier   = 32'd8;
      step();
      multiplicand = 32'hFFFF_FFFF;
      multiplier   = 32'd2;
      dcount     = 0;
      stable_err = 0;
      done_t[0]  = -1;
      done_t[1]  = -1;
      prod_s[0]  = '0;
      prod_s[1]  = '0;
      for (int i = 1; i <= 75; i++) begin
         step();
         if (done) begin
            if (dcount < 2) begin
               done_t[dcount] = i;
               prod_s[dcount] = product;
            end
            dcount++;
            if (dcount >= 2) start = 1'b0;
         end
         if (i > 32 && i < 65 && product !== ref_mul(32'd7, 32'd8)) stable_err++;
      end
      check("b2b done_count",  64'(dcount),     64'd2);
      check("b2b done0_edge",  64'(done_t[0]),  64'd32);
      check("b2b done1_edge",  64'(done_t[1]),  64'd65);
      check("b2b product0",    prod_s[0],       ref_mul(32'd7, 32'd8));
      check("b2b product1",    prod_s[1],       ref_mul(32'hFFFF_FFFF, 32'd2));
      check("b2b stable",      64'(stable_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time bound
   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1, "timeout");
   end

endmodule : tb_booth_multiplier_seq

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Sequential radix-2 Booth signed multiplier, 32x32 -> 64.
- Sits directly upstream of the 32-bit Adder_subtractor: each iteration it drives the adder's a, b and M inputs, then consumes sum back into its partial-product register.
- Gives the Kolache ALU a multiply operation without a second wide adder.
- Start/busy/done handshake toward the ALU control.

Parameters:
- WIDTH, 32, operand width. Must equal the adder width; only 32 is supported.
- CNT_W, 6, iteration counter width (holds 0..WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  32  signed operand X; latched on accepted start.
- multiplier  input  32  signed operand Y; latched on accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  64  signed X*Y; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal A=0, Q=0, q_m1=0, M_reg=0, count=0.
  - Takes effect immediately, including mid-RUN; the partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE, start=1: M_reg<=multiplicand, Q<=multiplier, A<=0, q_m1<=0, count<=0 -> RUN. With start=0, stay in IDLE.
- RUN, one Booth step per cycle, sel={Q[0],q_m1}:
  - 01: adder a=A, b=M_reg, M=0 (A+X).
  - 10: a=A, b=M_reg, M=1 (A-X).
  - 00/11: M=0, result taken as A (adder output ignored).
- Overflow-corrected sign:
  - add: ovf = (A[31]==M_reg[31]) & (sum[31]!=A[31]).
  - sub: ovf = (A[31]!=M_reg[31]) & (sum[31]!=A[31]).
  - s = sum[31]^ovf; in the no-op case s = A[31].
  - This makes X = -2^31 correct.
- Arithmetic shift right at the end of each RUN cycle: A <= {s, res[31:1]}, Q <= {res[0], Q[31:1]}, q_m1 <= Q[0]. res is sum or A, per sel.
- count increments each RUN cycle. On the cycle count==31 completes, the shifted {A,Q} is also written to product -> DONE.
- DONE (exactly one cycle): done=1, busy=0.
  - start=1 here: accepted as in IDLE, go to RUN; product still holds the old result.
  - otherwise -> IDLE.
- busy=1 exactly in RUN. start during RUN is ignored, and operand changes during RUN have no effect.
- Latency: start sampled at edge 0 -> 32 RUN cycles -> done high in the cycle after edge 32, with product valid then.
  - Accepted-start to accepted-start throughput: 33 cycles.
- Adder c_out is unused. Operands are two's complement; product is the exact 64-bit signed result for all inputs.
- done and busy are never high simultaneously.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH=32.
  - State encoding S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Booth select codes BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11.
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1 for the adder's M pin.
- Sub-module: one instance of the existing Adder_subtractor (ports a, b, M, sum, c_out). No other sub-modules.
- FSM, counter, shift register and overflow logic are local.

Test Plan:
- Reset, then start with X=3, Y=4 -> busy high for 32 cycles; done pulses 33 cycles after start; product=64'h0000_0000_0000_000C.
- X=-7 (32'hFFFF_FFF9), Y=6 -> product=64'hFFFF_FFFF_FFFF_FFD6; then X=32'hFFFF_FFFF, Y=32'hFFFF_FFFF -> product=64'h1.
- X=Y=32'h8000_0000 -> product=64'h4000_0000_0000_0000. Also X=32'h8000_0000, Y=1 -> 64'hFFFF_FFFF_8000_0000 (exercises ovf correction).
- Start with X=5, Y=6, then at cycle 10 pulse start with X=100, Y=100 -> second start ignored; product=30 at done; busy never drops early.
- Start with X=5, Y=6, drop rst_n at cycle 15 -> busy=0, done=0, product=0 immediately; no done follows. After release, a new start with X=2, Y=9 gives 18.
- Hold start=1 continuously with X=7, Y=8, changing operands to X=-1, Y=2 after the first accept -> done every 33 cycles; first product 56, second 64'hFFFF_FFFF_FFFF_FFFE; product stable between done pulses.
